mem8_arbiter_2port: RTL
=======================

Name: mem8_arbiter_2port

Overview:
- Round-robin arbiter and sequencer that shares one 8-byte memory (8 locations × 8 bits) between two requesters (port A, port B).
- Latches one request per transaction and drives the memory's address/read/write/chipselect for exactly one cycle.
- Captures read data and returns a one-cycle acknowledge to the granted requester.
- Sits between the two bus masters and the single memory instance; the memory's tristated output connects to mem_rdata.

Parameters:
- ADDR_W, 3, memory address width (8 locations).
- DATA_W, 8, data width.
- FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins ties.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request, level.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_rdata  output  DATA_W  port A read result, valid when a_ack=1 and held until the next port A read completes.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read enable.
- mem_cs  output  1  memory output-buffer chipselect.
- mem_rdata  input  DATA_W  memory read data (tristated when not selected).
- busy  output  1  high whenever state is not IDLE.
- grant_b  output  1  owner of current or last transaction: 0 = A, 1 = B.

Behaviour:
Reset
- Asynchronous, active-low, effective immediately regardless of state.
- Values: state=IDLE; all mem_* outputs, a_ack, b_ack, busy = 0; a_rdata = b_rdata = 0; last-grant register = B, so A wins the first tie; grant_b = 0.
- Reset mid-transaction aborts it: no ack is issued; a write whose ACCESS edge did not complete is not committed.

State machine (IDLE -> ACCESS -> RESP -> IDLE)
- IDLE: requests are sampled only in this state.
  - Neither request high: stay in IDLE.
  - One request high: grant it.
  - Both high: FAIR=1 grants the port not granted last; FAIR=0 grants A.
  - On the granting edge: latch we, addr and wdata of the winner; set grant_b; update last-grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata are driven from the latches.
  - Write: mem_wr=1, mem_rd=0, mem_cs=0. The memory commits on the edge that ends ACCESS.
  - Read: mem_rd=1, mem_cs=1, mem_wr=0. mem_rdata is captured into the owner's rdata register on the edge that ends ACCESS; the other port's rdata is unchanged.
  - Next state: RESP.
- RESP (one cycle): owner's ack=1, all mem strobes = 0. Next state: IDLE.
- mem_addr and mem_wdata hold their last values outside ACCESS; only the strobes qualify them.

Latency and throughput
- Request high at edge N (in IDLE) -> ACCESS during cycle N+1 -> ack high during cycle N+2.
- Maximum throughput is one transaction per 3 cycles.

Handshake
- Requester fields are latched at grant; the requester may change them after the grant edge.
- Dropping req after grant does not cancel the transaction; ack is still issued.
- A req still high when the FSM returns to IDLE is a new transaction. To perform a single transaction, the requester deasserts req in the cycle ack is seen.
- Requests arriving during ACCESS or RESP wait; there is no queueing beyond the level req.

Invariants
- mem_wr and mem_rd are never both high.
- a_ack and b_ack are never both high.
- Strobes are high only in ACCESS.

Test Plan:
- Reset, then A writes 0x5A to addr 3 (single req pulse) -> mem_wr=1 with mem_addr=3 for exactly one cycle; a_ack high 2 cycles after the grant edge; b_ack stays 0.
- A reads addr 3 -> mem_rd=mem_cs=1 for one cycle; a_rdata=0x5A when a_ack=1; b_rdata still 0.
- A and B both request continuously from reset with FAIR=1 (A writes addr0/0x11, B writes addr1/0x22) -> grants alternate A,B,A,B; one ack every 3 cycles; memory holds addr0=0x11, addr1=0x22.
- Same stimulus with FAIR=0 -> A granted every time; b_ack never asserted while a_req stays high.
- B drops b_req one cycle after grant -> transaction completes and b_ack still pulses; no second transaction follows.
- reset asserted during the ACCESS cycle of a B write of 0xFF to addr 7 -> all outputs 0 immediately; no b_ack; after release, a read of addr 7 returns 0x00 (memory also reset).

Source files
------------

// File: rtl/mem8_arbiter_2port_if.sv
// Bus bundle between the two requesters, the arbiter and the shared 8-byte memory.
// The slave modport is the arbiter's view. The master modport is the requester and memory side.
interface mem8_arbiter_2port_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic              mem_rd;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant_b;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_wr, mem_rd, mem_cs,
        input  mem_rdata,
        output busy, grant_b
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_wr, mem_rd, mem_cs,
        output mem_rdata,
        input  busy, grant_b
    );
endinterface

// File: rtl/mem8_arbiter_2port.sv
// Arbiter and sequencer for two requesters sharing one 8x8 memory.
// Each transaction runs IDLE -> ACCESS -> RESP, with round-robin or A-priority arbitration.
module mem8_arbiter_2port #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int FAIR   = 1
) (
    input logic                    clk,
    input logic                    reset,
    mem8_arbiter_2port_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_b_q, grant_b_d;
    logic              last_b_q, last_b_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              pick_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_b_q <= 1'b0;
            // Last grant resets to B so that A wins the first tie.
            last_b_q  <= 1'b1;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_b_q <= grant_b_d;
            last_b_q  <= last_b_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_b_d = grant_b_q;
        last_b_d  = last_b_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    pick_b    = bus.b_req && (!bus.a_req || ((FAIR != 0) && !last_b_q));
                    we_d      = pick_b ? bus.b_we    : bus.a_we;
                    addr_d    = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d   = pick_b ? bus.b_wdata : bus.a_wdata;
                    grant_b_d = pick_b;
                    last_b_d  = pick_b;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (grant_b_q) b_rdata_d = bus.mem_rdata;
                    else           a_rdata_d = bus.mem_rdata;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = (state_q == ACCESS) &&  we_q;
    assign bus.mem_rd    = (state_q == ACCESS) && !we_q;
    assign bus.mem_cs    = (state_q == ACCESS) && !we_q;
    assign bus.a_ack     = (state_q == RESP) && !grant_b_q;
    assign bus.b_ack     = (state_q == RESP) &&  grant_b_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_b   = grant_b_q;
endmodule
